icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache that sits upstream of the Riscv141 fetch stage. It accepts the core's icache_addr/icache_re, returns icache_dout, and drives the core's stall input. On a miss it refills one line from main memory over a valid/ready request channel and an in-order word-beat response channel. It also keeps hit and miss counters for CSR and performance readout.

---
 rtl/icache_dm_if.sv | 26 ++
 rtl/icache_dm.sv | 145 ++++++++++++++
 tb/tb_icache_dm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Bundles the fetch-side and memory-refill-side signals of the icache_dm instruction cache.
// The cache drives through the master modport; core/memory models use the slave modport.
interface icache_dm_if;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        input  cpu_addr, cpu_re, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_dout, stall, mem_req_valid, mem_req_addr, hit_count, miss_count
    );

    modport slave (
        output cpu_addr, cpu_re, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_dout, stall, mem_req_valid, mem_req_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-line refill over a
// valid/ready request channel and an in-order word-beat response channel.
module icache_dm #(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    icache_dm_if.master bus
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {LOOKUP, MREQ, MFILL, RESP} state_t;

    state_t state, state_nxt;

    logic [31:2]      req_q;
    logic             pend_q;
    logic [OFF_W-1:0] cnt;
    logic [LINES-1:0] valid, valid_nxt;
    logic [31:0]      hit_cnt, miss_cnt, dout_q;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];
    logic             valid_rd;
    logic [TAG_W-1:0] tag_rd;
    logic [31:0]      data_rd, fill_word;

    logic             stall, mem_req_valid, hit, fill_beat, fill_last;
    logic [31:0]      mem_req_addr, cpu_dout;

    logic [IDX_W-1:0] cpu_idx, req_idx;
    logic [OFF_W-1:0] cpu_off, req_off;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       unused_byte_bits;

    assign cpu_idx = bus.cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign cpu_off = bus.cpu_addr[OFF_W+1:2];
    assign req_idx = req_q[IDX_W+OFF_W+1:OFF_W+2];
    assign req_off = req_q[OFF_W+1:2];
    assign req_tag = req_q[31:IDX_W+OFF_W+2];
    assign unused_byte_bits = bus.cpu_addr[1:0];

    assign hit       = pend_q && valid_rd && (tag_rd == req_tag);
    assign fill_beat = (state == MFILL) && bus.mem_resp_valid;
    assign fill_last = fill_beat && (cnt == OFF_W'(WORDS - 1));

    // A flush clears everything, but a line completing its refill on the same edge still lands valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        valid_nxt = bus.flush ? '0 : valid;
        if (fill_last) valid_nxt[req_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOOKUP;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOOKUP: if (pend_q && !hit)     state_nxt = MREQ;
            MREQ:   if (bus.mem_req_ready)  state_nxt = MFILL;
            MFILL:  if (fill_last)          state_nxt = RESP;
            RESP:                           state_nxt = LOOKUP;
            default:                        state_nxt = LOOKUP;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        cpu_dout      = dout_q;
        unique case (state)
            LOOKUP: begin
                stall = pend_q && !hit;
                if (hit) cpu_dout = data_rd;
            end
            MREQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_q[31:OFF_W+2], (OFF_W+2)'(0)};
            end
            MFILL:   stall    = 1'b1;
            RESP:    cpu_dout = fill_word;
            default: stall    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= '0;
            pend_q   <= 1'b0;
            cnt      <= '0;
            valid    <= '0;
            valid_rd <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            dout_q   <= '0;
        end else begin
            valid  <= valid_nxt;
            dout_q <= cpu_dout;
            if (!stall) begin
                req_q    <= bus.cpu_addr[31:2];
                pend_q   <= bus.cpu_re;
                // The read port sees a flush on the same edge so the following lookup misses.
                valid_rd <= bus.flush ? 1'b0 : valid[cpu_idx];
            end
            if ((state == MREQ) && bus.mem_req_ready) cnt <= '0;
            else if (fill_beat)                       cnt <= cnt + 1'b1;
            if ((state == LOOKUP) && pend_q) begin
                if (hit) hit_cnt  <= hit_cnt + 32'd1;
                else     miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    // NOTE: tag/data arrays and their read registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[{req_idx, cnt}] <= bus.mem_resp_data;
            if (cnt == req_off) fill_word <= bus.mem_resp_data;
            if (fill_last)      tag_mem[req_idx] <= req_tag;
        end
        if (!stall) begin
            tag_rd  <= tag_mem[cpu_idx];
            data_rd <= data_mem[{cpu_idx, cpu_off}];
        end
    end

    assign bus.cpu_dout      = cpu_dout;
    assign bus.stall         = stall;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = mem_req_addr;
    assign bus.hit_count     = hit_cnt;
    assign bus.miss_count    = miss_cnt;
endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a residency-map model of a
// direct-mapped cache (64 lines x 4 words) and a fixed memory content function.
module tb_icache_dm;
    localparam int LINES = 64;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_dm_if bus ();

    icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int refills = 0;

    // Reference model: which line address (addr[31:4]) is resident at each index.
    bit          res_valid [LINES];
    logic [27:0] res_line  [LINES];
    int          m_hits   = 0;
    int          m_misses = 0;
    logic [31:0] last_dout = 32'h0;

    always @(posedge clk) if (bus.mem_req_valid && bus.mem_req_ready) refills++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h0000010) return 32'hA0 + 32'(w[3:2]);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        last_dout = 32'h0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"},   bus.hit_count,  32'(m_hits));
        check({tag, "_misses"}, bus.miss_count, 32'(m_misses));
    endtask

    task automatic handshake(input logic [31:0] line, input int dly);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            check("req_valid", 32'(bus.mem_req_valid), 32'd1);
            check("req_addr",  bus.mem_req_addr, line);
            check("req_stall", 32'(bus.stall), 32'd1);
            if (c == dly) bus.mem_req_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input int gap, input bit fl);
        repeat (gap) begin
            @(negedge clk);
            check("fill_stall", 32'(bus.stall), 32'd1);
        end
        @(negedge clk);
        check("fill_stall", 32'(bus.stall), 32'd1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = d;
        bus.flush          = fl;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        bus.flush          = 1'b0;
    endtask

    // One fetch from an idle cache (called #1 after a rising edge). fl >= 0 pulses
    // flush: in the lookup cycle on a hit, or together with beat fl on a miss.
    task automatic fetch(input logic [31:0] a, input int dly, input int gap, input int fl);
        logic [31:0] line, exp_word;
        int idx;
        bit exp_hit;
        line     = {a[31:4], 4'h0};
        idx      = int'(a[9:4]);
        exp_word = mem_word(a);
        exp_hit  = res_valid[idx] && (res_line[idx] == a[31:4]);
        bus.cpu_addr = a;
        bus.cpu_re   = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_stall", 32'(bus.stall), 32'd0);
            check("hit_data",  bus.cpu_dout, exp_word);
            check("hit_noreq", 32'(bus.mem_req_valid), 32'd0);
            if (fl >= 0) bus.flush = 1'b1;
            bus.cpu_re = 1'b0;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            m_hits++;
            if (fl >= 0) model_flush();
        end else begin
            check("miss_stall", 32'(bus.stall), 32'd1);
            m_misses++;
            @(posedge clk); #1;
            handshake(line, dly);
            for (int b = 0; b < WORDS; b++)
                beat(mem_word(line + 32'(4 * b)), gap, fl == b);
            @(negedge clk);
            check("resp_stall", 32'(bus.stall), 32'd0);
            check("resp_data",  bus.cpu_dout, exp_word);
            bus.cpu_re = 1'b0;
            @(posedge clk); #1;
            if (fl >= 0) model_flush();
            res_valid[idx] = 1'b1;
            res_line[idx]  = a[31:4];
        end
        last_dout = exp_word;
        check_counters("cnt");
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_stall", 32'(bus.stall), 32'd0);
        check("idle_dout",  bus.cpu_dout, last_dout);
        check("idle_noreq", 32'(bus.mem_req_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  bus.cpu_dout, 32'h0);
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_reqv"},  32'(bus.mem_req_valid), 32'd0);
        check({tag, "_reqa"},  bus.mem_req_addr, 32'h0);
        check({tag, "_hits"},  bus.hit_count, 32'h0);
        check({tag, "_miss"},  bus.miss_count, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bus.cpu_addr = '0;
        bus.cpu_re = 1'b0;
        bus.flush = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_check();

        // Cold miss with the 0xA0.. line, then hits on the same line.
        fetch(32'h0000_0104, 0, 0, -1);
        fetch(32'h0000_0100, 0, 0, -1);
        fetch(32'h0000_0108, 0, 0, -1);
        fetch(32'h0000_010C, 0, 0, -1);
        check("hits_after_line", bus.hit_count, 32'd3);
        idle_check();

        // Conflict misses on one index.
        fetch(32'h0000_0500, 0, 0, -1);
        fetch(32'h0000_0100, 1, 0, -1);
        check("conflict_misses", bus.miss_count, 32'd3);

        // Slow ready and spaced beats: exactly one refill.
        r0 = refills;
        fetch(32'h0000_1240, 5, 3, -1);
        check("one_refill", 32'(refills - r0), 32'd1);

        // Flush during refill, and flush on the final beat.
        fetch(32'h0000_0200, 0, 0, -1);
        fetch(32'h0000_0500, 0, 0, -1);
        fetch(32'h0000_0100, 0, 1, 2);
        fetch(32'h0000_0104, 0, 0, -1);
        fetch(32'h0000_0200, 0, 0, -1);
        fetch(32'h0000_0300, 0, 0, 3);
        fetch(32'h0000_0204, 0, 0, -1);
        fetch(32'h0000_0308, 0, 0, -1);
        // Flush on a hit cycle: the hit stands, the next lookup misses.
        fetch(32'h0000_030C, 0, 0, 0);
        fetch(32'h0000_030C, 0, 0, -1);

        // Reset in the middle of a refill, then stray beats.
        bus.cpu_addr = 32'h0000_0100;
        bus.cpu_re = 1'b1;
        @(posedge clk); #1;
        fetch_start_check();
        @(posedge clk); #1;
        handshake(32'h0000_0100, 0);
        beat(32'h0000_00A0, 0, 1'b0);
        beat(32'h0000_00A1, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.cpu_re = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hDEAD_0000 + 32'(i);
            @(negedge clk);
            check_all_zero("stray");
        end
        bus.mem_resp_valid = 1'b0;
        @(posedge clk); #1;
        fetch(32'h0000_0100, 0, 0, -1);
        fetch(32'h0000_010C, 0, 0, -1);

        // Randomized fetches over a small address pool so hits and conflicts both occur.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int fl;
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), fl);
            if ($urandom_range(0, 3) == 0) idle_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic fetch_start_check();
        @(negedge clk);
        check("rst_miss_stall", 32'(bus.stall), 32'd1);
    endtask
endmodule
